// File: rtl/hs4_responder_if.sv
// Bundles the 4-phase req/ack/data handshake with the local producer push port.
// The master side is the initiator/producer; the slave side is the responder.
interface hs4_responder_if #(
  parameter int DATA_W = 8
) ();
  logic              req;
  logic              ack;
  logic [DATA_W:0]   data;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output req, wr_valid, wr_data,
    input  ack, data, wr_ready
  );

  modport slave (
    input  req, wr_valid, wr_data,
    output ack, data, wr_ready
  );
endinterface

// File: rtl/hs4_responder.sv
// Responder end of the 4-phase req/ack/data handshake: answers each request with ack
// and a fresh word from an internal write FIFO, flagging underflow and early aborts.
module hs4_responder #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ACK_DELAY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  hs4_responder_if.slave           bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              xfer_cnt,
  output logic                     underflow,
  output logic                     proto_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, STRETCH, ACK_ON, UPDATE, HOLD} state_t;

  state_t            state, state_nxt;
  logic              req_q, rise, fall;
  logic              ack_q, ack_nxt;
  logic              do_update, abort;
  logic [DATA_W:0]   data_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  assign rise  = bus.req & ~req_q;
  assign fall  = ~bus.req & req_q;
  assign full  = (fifo_level == LVL_W'(DEPTH));
  assign empty = (fifo_level == '0);
  assign push  = bus.wr_valid & ~full;
  assign pop   = do_update & ~empty;

  assign bus.wr_ready = ~full;
  assign bus.ack      = ack_q;
  assign bus.data     = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= bus.req;
      ack_q <= ack_nxt;
    end
  end

  // A fall seen before HOLD still finishes the update, then heads straight back to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise) state_nxt = (ACK_DELAY == 1) ? STRETCH : ACK_ON;
      STRETCH: state_nxt = bus.req ? ACK_ON : IDLE;
      ACK_ON:  state_nxt = UPDATE;
      UPDATE:  state_nxt = (fall || !ack_q) ? IDLE : HOLD;
      HOLD:    if (fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt   = ack_q;
    do_update = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE:    ack_nxt = rise && (ACK_DELAY == 0);
      STRETCH: begin
        ack_nxt = bus.req;
        abort   = ~bus.req;
      end
      ACK_ON:  begin
        ack_nxt   = ~fall;
        do_update = 1'b1;
      end
      UPDATE:  ack_nxt = ack_q & ~fall;
      HOLD:    ack_nxt = ~fall;
      default: ack_nxt = 1'b0;
    endcase
  end

  // The toggle bit flips on every transfer so data visibly changes even on repeats or underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      underflow  <= 1'b0;
      proto_err  <= 1'b0;
      xfer_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_update) begin
        data_q[DATA_W] <= ~data_q[DATA_W];
        xfer_cnt       <= xfer_cnt + 16'd1;
        if (empty) underflow <= 1'b1;
        else       data_q[DATA_W-1:0] <= mem[rd_ptr];
      end
      if (abort) proto_err <= 1'b1;
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end
endmodule

// File: tb/tb_hs4_responder.sv
// Self-checking bench for hs4_responder: one instance per ACK_DELAY setting, a vector table,
// hand-written corner sequences and a randomized run against a queue-based reference model.
module tb_hs4_responder;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  typedef struct {
    int              n_push;
    logic [7:0]      word;
    int              hold;
    logic [8:0]      exp_data;
    logic            exp_under;
    int              exp_xfer;
    int              exp_level;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic sel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic       m_tog;
  logic [7:0] m_pay;
  logic       m_under;
  int         m_xfer;
  logic [8:0] last_data;

  always #5 clk = ~clk;

  hs4_responder_if #(.DATA_W(DATA_W)) bus0 ();
  hs4_responder_if #(.DATA_W(DATA_W)) bus1 ();

  logic [LVL_W-1:0] level0, level1;
  logic [15:0]      xfer0, xfer1;
  logic             under0, under1, proto0, proto1;

  hs4_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .fifo_level(level0), .xfer_cnt(xfer0), .underflow(under0), .proto_err(proto0)
  );

  hs4_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .fifo_level(level1), .xfer_cnt(xfer1), .underflow(under1), .proto_err(proto1)
  );

  // Only the selected instance sees requests and pushes; the other idles.
  assign bus0.req      = req & ~sel;
  assign bus1.req      = req & sel;
  assign bus0.wr_valid = wr_valid & ~sel;
  assign bus1.wr_valid = wr_valid & sel;
  assign bus0.wr_data  = wr_data;
  assign bus1.wr_data  = wr_data;

  logic             dut_ack, dut_ready, dut_under, dut_proto;
  logic [8:0]       dut_data;
  logic [LVL_W-1:0] dut_level;
  logic [15:0]      dut_xfer;

  assign dut_ack   = sel ? bus1.ack      : bus0.ack;
  assign dut_data  = sel ? bus1.data     : bus0.data;
  assign dut_ready = sel ? bus1.wr_ready : bus0.wr_ready;
  assign dut_level = sel ? level1        : level0;
  assign dut_xfer  = sel ? xfer1         : xfer0;
  assign dut_under = sel ? under1        : under0;
  assign dut_proto = sel ? proto1        : proto0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_tog     = 1'b0;
    m_pay     = '0;
    m_under   = 1'b0;
    m_xfer    = 0;
    last_data = '0;
  endtask

  task automatic model_push(input logic [7:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
  endtask

  task automatic model_xfer(output logic [8:0] e);
    m_tog = ~m_tog;
    if (mq.size() > 0) m_pay = mq.pop_front();
    else               m_under = 1'b1;
    m_xfer = (m_xfer + 1) % 65536;
    e = {m_tog, m_pay};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    wr_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    model_reset();
    check_output("rst_ack",   32'(dut_ack),   32'(0));
    check_output("rst_data",  32'(dut_data),  32'(0));
    check_output("rst_level", 32'(dut_level), 32'(0));
    check_output("rst_xfer",  32'(dut_xfer),  32'(0));
    check_output("rst_under", 32'(dut_under), 32'(0));
    check_output("rst_proto", 32'(dut_proto), 32'(0));
    check_output("rst_ready", 32'(dut_ready), 32'(1));
  endtask

  task automatic do_push(input logic [7:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  // ack must rise 1 (or 2 with stretch) edges after req is sampled high, data one edge later.
  task automatic do_handshake(input int hold, input logic [8:0] exp);
    req = 1'b1;
    if (sel) begin
      tick();
      check_output("stretch_ack_low", 32'(dut_ack), 32'(0));
    end
    tick();
    check_output("ack_rise", 32'(dut_ack), 32'(1));
    check_output("data_before_update", 32'(dut_data), 32'(last_data));
    tick();
    check_output("data_update", 32'(dut_data), 32'(exp));
    check_output("ack_held", 32'(dut_ack), 32'(1));
    repeat (hold) tick();
    check_output("data_stable", 32'(dut_data), 32'(exp));
    req = 1'b0;
    tick();
    check_output("ack_fall", 32'(dut_ack), 32'(0));
    tick();
    check_output("ack_idle", 32'(dut_ack), 32'(0));
    last_data = exp;
  endtask

  task automatic apply_stimulus(input vec_t v);
    repeat (v.n_push) do_push(v.word);
    do_handshake(v.hold, v.exp_data);
    check_output("vec_level", 32'(dut_level), 32'(v.exp_level));
    check_output("vec_xfer",  32'(dut_xfer),  32'(v.exp_xfer));
    check_output("vec_under", 32'(dut_under), 32'(v.exp_under));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [8:0] e, e2;

    vecs[0] = '{1, 8'h5A, 8, 9'h15A, 1'b0, 1, 0};
    vecs[1] = '{2, 8'hAA, 2, 9'h0AA, 1'b0, 2, 1};
    vecs[2] = '{0, 8'h00, 1, 9'h1AA, 1'b0, 3, 0};
    vecs[3] = '{0, 8'h00, 3, 9'h0AA, 1'b1, 4, 0};
    vecs[4] = '{1, 8'h3C, 0, 9'h13C, 1'b1, 5, 0};

    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

    // Fill past capacity: the extra word must be dropped.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      check_output("full_ready", 32'(dut_ready), 32'(i < DEPTH));
      model_push(8'hC0 + 8'(i));
      do_push(8'hC0 + 8'(i));
    end
    check_output("full_level", 32'(dut_level), 32'(DEPTH));
    check_output("full_ready_end", 32'(dut_ready), 32'(0));
    for (int i = 0; i <= DEPTH; i++) begin
      model_xfer(e);
      do_handshake(1, e);
    end
    check_output("drain_under", 32'(dut_under), 32'(m_under));
    check_output("drain_xfer", 32'(dut_xfer), 32'(m_xfer));

    // req drops while in ACK_ON: update completes, ack clears one cycle after the fall.
    do_reset();
    model_push(8'h11);
    do_push(8'h11);
    model_xfer(e);
    req = 1'b1;
    tick();
    check_output("early_ack_rise", 32'(dut_ack), 32'(1));
    req = 1'b0;
    tick();
    check_output("early_ack_fall", 32'(dut_ack), 32'(0));
    check_output("early_data", 32'(dut_data), 32'(e));
    tick();
    check_output("early_ack_idle", 32'(dut_ack), 32'(0));
    check_output("early_xfer", 32'(dut_xfer), 32'(m_xfer));
    check_output("early_proto", 32'(dut_proto), 32'(0));
    last_data = e;

    // Push landing on the update edge of an empty FIFO: underflow, word retained.
    model_xfer(e);
    model_push(8'h77);
    req = 1'b1;
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tick();
    wr_valid = 1'b0;
    check_output("bypass_data", 32'(dut_data), 32'(e));
    check_output("bypass_under", 32'(dut_under), 32'(1));
    check_output("bypass_level", 32'(dut_level), 32'(1));
    req = 1'b0;
    tick();
    tick();
    last_data = e;
    model_xfer(e2);
    do_handshake(2, e2);
    check_output("bypass_payload", 32'(dut_data[7:0]), 32'(8'h77));

    // Asynchronous reset while holding ack.
    do_reset();
    model_push(8'h42);
    do_push(8'h42);
    req = 1'b1;
    tick();
    tick();
    tick();
    check_output("hold_ack", 32'(dut_ack), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check_output("async_ack", 32'(dut_ack), 32'(0));
    check_output("async_data", 32'(dut_data), 32'(0));
    check_output("async_level", 32'(dut_level), 32'(0));
    check_output("async_xfer", 32'(dut_xfer), 32'(0));
    req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    model_reset();
    model_push(8'h5A);
    do_push(8'h5A);
    model_xfer(e);
    do_handshake(3, e);
    check_output("post_rst_data", 32'(dut_data), 32'(9'h15A));
    check_output("post_rst_xfer", 32'(dut_xfer), 32'(1));
    check_output("post_rst_level", 32'(dut_level), 32'(0));

    // Stretched responder: normal transfer, then a one-cycle req pulse that must abort.
    sel = 1'b1;
    do_reset();
    model_push(8'h33);
    do_push(8'h33);
    model_xfer(e);
    do_handshake(2, e);
    check_output("stretch_data", 32'(dut_data), 32'(9'h133));
    req = 1'b1;
    tick();
    check_output("abort_ack0", 32'(dut_ack), 32'(0));
    req = 1'b0;
    tick();
    check_output("abort_ack1", 32'(dut_ack), 32'(0));
    check_output("abort_proto", 32'(dut_proto), 32'(1));
    tick();
    check_output("abort_ack2", 32'(dut_ack), 32'(0));
    check_output("abort_xfer", 32'(dut_xfer), 32'(1));
    model_push(8'h9C);
    do_push(8'h9C);
    model_xfer(e);
    do_handshake(1, e);
    check_output("abort_sticky", 32'(dut_proto), 32'(1));

    // Randomized run on both instances against the queue model.
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      do_reset();
      for (int it = 0; it < 25; it++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) begin
          logic [7:0] w;
          w = 8'($urandom);
          check_output("rnd_ready", 32'(dut_ready), 32'(mq.size() < DEPTH));
          model_push(w);
          do_push(w);
        end
        model_xfer(e);
        do_handshake(int'($urandom_range(0, 4)), e);
        check_output("rnd_level", 32'(dut_level), 32'(mq.size()));
        check_output("rnd_xfer",  32'(dut_xfer),  32'(m_xfer));
        check_output("rnd_under", 32'(dut_under), 32'(m_under));
        check_output("rnd_proto", 32'(dut_proto), 32'(0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
